// File: rtl/mem_pkg.sv
// Shared types and helpers for the dual-port word memory.
// Holds the word geometry, the init FSM state type and the byte-lane merge.
package mem_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        INIT  = 2'd1,
        READY = 2'd2
    } mem_state_t;

    function automatic logic [WORD_W-1:0] lane_merge(
        input logic [WORD_W-1:0]         old_w,
        input logic [WORD_W-1:0]         new_w,
        input logic [BYTES_PER_WORD-1:0] we
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (we[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Post-reset sequencer: optionally zeroes every word, then raises ready.
// Drives the clear write port that the top muxes into the storage array.
module mem_clear_fsm
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int CLEAR_ON_RESET = 1,
    parameter int IDX_W          = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             clear_we,
    output logic [IDX_W-1:0] clear_idx,
    output logic             ready
);

    localparam mem_state_t       RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : INIT;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

    mem_state_t       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    // Next-state logic: walk the clear counter, then settle in READY for good.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            INIT: begin
                state_d = READY;
                ready_d = 1'b1;
            end
            READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = {IDX_W{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // FSM registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= {IDX_W{1'b0}};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign clear_we  = (state_q == CLEAR);
    assign clear_idx = cnt_q;
    assign ready     = ready_q;

endmodule

// File: rtl/dual_port_mem.sv
// Dual-port 32-bit word memory serving the instruction and data bus ports.
// Read-first, byte-lane writes, 1-cycle read latency; data port wins lane collisions.
module dual_port_mem
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [31:0]       addr_inst,
    input  logic [WORD_W-1:0] wdata_inst,
    input  logic              en_inst,
    input  logic [3:0]        we_inst,
    output logic [WORD_W-1:0] rdata_inst,
    output logic              err_inst,
    input  logic [31:0]       addr_data,
    input  logic [WORD_W-1:0] wdata_data,
    input  logic              en_data,
    input  logic [3:0]        we_data,
    output logic [WORD_W-1:0] rdata_data,
    output logic              err_data,
    output logic              ready
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

    logic              ready_s, clear_we_s;
    logic [AW-1:0]     clear_idx_s;
    logic [AW-1:0]     idx_inst_s, idx_data_s;
    logic              oor_inst_s, oor_data_s;
    logic              wr_inst_s, wr_data_s, same_word_s;
    logic [WORD_W-1:0] merged_inst_s, merged_data_s;
    logic [WORD_W-1:0] rdata_inst_q, rdata_inst_d, rdata_data_q, rdata_data_d;
    logic              err_inst_q, err_inst_d, err_data_q, err_data_d;
    logic              unused_addr_lsb_s;

    mem_clear_fsm #(
        .DEPTH_WORDS    (DEPTH_WORDS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .IDX_W          (AW)
    ) u_clear_fsm (
        .clk       (aclk),
        .rst_n     (aresetn),
        .clear_we  (clear_we_s),
        .clear_idx (clear_idx_s),
        .ready     (ready_s)
    );

    // Byte address lsbs carry no meaning for a word-only memory.
    assign unused_addr_lsb_s = ^{addr_inst[1:0], addr_data[1:0]};

    assign idx_inst_s = addr_inst[AW+1:2];
    assign idx_data_s = addr_data[AW+1:2];
    assign oor_inst_s = |addr_inst[31:AW+2];
    assign oor_data_s = |addr_data[31:AW+2];

    // Write decode; on a shared word the data lanes are layered over the instruction lanes.
    always_comb begin
        wr_inst_s     = ready_s & en_inst & (|we_inst) & ~oor_inst_s;
        wr_data_s     = ready_s & en_data & (|we_data) & ~oor_data_s;
        same_word_s   = wr_inst_s & wr_data_s & (idx_inst_s == idx_data_s);
        merged_inst_s = lane_merge(mem_q[idx_inst_s], wdata_inst, we_inst);
        merged_data_s = lane_merge(same_word_s ? merged_inst_s : mem_q[idx_data_s],
                                   wdata_data, we_data);
    end

    // Storage writes: the clear sequence owns the array until ready rises.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            if (clear_we_s) begin
                mem_q[clear_idx_s] <= {WORD_W{1'b0}};
            end else begin
                if (wr_inst_s && !same_word_s) begin
                    mem_q[idx_inst_s] <= merged_inst_s;
                end
                if (wr_data_s) begin
                    mem_q[idx_data_s] <= merged_data_s;
                end
            end
        end
    end

    // Read response: old word (read-first), zero when out of range or not ready, hold when idle.
    always_comb begin
        rdata_inst_d = rdata_inst_q;
        rdata_data_d = rdata_data_q;
        err_inst_d   = 1'b0;
        err_data_d   = 1'b0;
        if (!ready_s) begin
            rdata_inst_d = {WORD_W{1'b0}};
            rdata_data_d = {WORD_W{1'b0}};
        end else begin
            if (en_inst) begin
                rdata_inst_d = oor_inst_s ? {WORD_W{1'b0}} : mem_q[idx_inst_s];
                err_inst_d   = oor_inst_s;
            end else begin
                rdata_inst_d = rdata_inst_q;
            end
            if (en_data) begin
                rdata_data_d = oor_data_s ? {WORD_W{1'b0}} : mem_q[idx_data_s];
                err_data_d   = oor_data_s;
            end else begin
                rdata_data_d = rdata_data_q;
            end
        end
    end

    // Response registers; reset drops any read in flight.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rdata_inst_q <= {WORD_W{1'b0}};
            rdata_data_q <= {WORD_W{1'b0}};
            err_inst_q   <= 1'b0;
            err_data_q   <= 1'b0;
        end else begin
            rdata_inst_q <= rdata_inst_d;
            rdata_data_q <= rdata_data_d;
            err_inst_q   <= err_inst_d;
            err_data_q   <= err_data_d;
        end
    end

    assign rdata_inst = rdata_inst_q;
    assign rdata_data = rdata_data_q;
    assign err_inst   = err_inst_q;
    assign err_data   = err_data_q;
    assign ready      = ready_s;

endmodule

// File: tb/tb_dual_port_mem.sv
// Scoreboard bench for dual_port_mem with DEPTH_WORDS=16 and clear-on-reset.
// Stimulus pushes expected {err,rdata} per port; a negedge monitor pops and compares.
module tb_dual_port_mem;

    localparam int DEPTH = 16;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] addr_inst, wdata_inst, rdata_inst;
    logic [31:0] addr_data, wdata_data, rdata_data;
    logic        en_inst, en_data, err_inst, err_data, ready;
    logic [3:0]  we_inst, we_data;

    logic [32:0] q_inst [$];
    logic [32:0] q_data [$];
    logic        chk_inst = 1'b0;
    logic        chk_data = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;

    dual_port_mem #(.DEPTH_WORDS(DEPTH), .CLEAR_ON_RESET(1)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .addr_inst  (addr_inst),
        .wdata_inst (wdata_inst),
        .en_inst    (en_inst),
        .we_inst    (we_inst),
        .rdata_inst (rdata_inst),
        .err_inst   (err_inst),
        .addr_data  (addr_data),
        .wdata_data (wdata_data),
        .en_data    (en_data),
        .we_data    (we_data),
        .rdata_data (rdata_data),
        .err_data   (err_data),
        .ready      (ready)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%09h expected 0x%09h at %0t", name, act, exp, $time);
        end
    endtask

    // Remember which ports issued an access at this edge.
    always @(posedge aclk) begin
        chk_inst <= en_inst;
        chk_data <= en_data;
    end

    // Monitor: compare each response against the oldest expectation.
    always @(negedge aclk) begin
        if (chk_inst) begin
            if (q_inst.size() == 0) check("inst_unexpected", {err_inst, rdata_inst}, 33'h1_FFFF_FFFF);
            else check("inst_rsp", {err_inst, rdata_inst}, q_inst.pop_front());
        end
        if (chk_data) begin
            if (q_data.size() == 0) check("data_unexpected", {err_data, rdata_data}, 33'h1_FFFF_FFFF);
            else check("data_rsp", {err_data, rdata_data}, q_data.pop_front());
        end
    end

    task automatic drv_i(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic [31:0] exp_rd, input logic exp_err);
        en_inst = 1'b1; addr_inst = a; wdata_inst = wd; we_inst = we;
        q_inst.push_back({exp_err, exp_rd});
    endtask

    task automatic drv_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic [31:0] exp_rd, input logic exp_err);
        en_data = 1'b1; addr_data = a; wdata_data = wd; we_data = we;
        q_data.push_back({exp_err, exp_rd});
    endtask

    task automatic step();
        @(negedge aclk);
        en_inst = 1'b0; we_inst = 4'h0;
        en_data = 1'b0; we_data = 4'h0;
    endtask

    task automatic wait_ready(input logic with_acc);
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            check("ready_ramp", {32'h0, ready}, {32'h0, (i == DEPTH)});
            if (with_acc && i == DEPTH - 3) drv_d(32'h30, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b0);
            if (with_acc && i == DEPTH - 2) drv_d(32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn = 1'b0;
        en_inst = 1'b0; addr_inst = 32'h0; wdata_inst = 32'h0; we_inst = 4'h0;
        en_data = 1'b0; addr_data = 32'h0; wdata_data = 32'h0; we_data = 4'h0;
        repeat (3) @(negedge aclk);
        check("reset_state", {err_inst, err_data, ready, rdata_inst ^ rdata_data},
              {3'b000, 30'h0, 2'b00} >> 0);
        check("reset_rdata_inst", {1'b0, rdata_inst}, 33'h0);
        aresetn = 1'b1;
        wait_ready(1'b0);

        // Every word reads zero after the clear, back-to-back on the inst port.
        for (int k = 0; k < DEPTH; k++) begin
            drv_i(32'(k * 4), 32'h0, 4'h0, 32'h0, 1'b0);
            step();
        end

        // Full write then a single-lane write; each returns the pre-write word.
        drv_d(32'h10, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);         step();
        drv_d(32'h10, 32'h0000_AA00, 4'b0010, 32'hDEAD_BEEF, 1'b0); step();
        drv_d(32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);          step();

        // Same-word collision: data lanes 0..1 override the instruction write.
        drv_i(32'h20, 32'h1122_3344, 4'hF, 32'h0, 1'b0);
        drv_d(32'h20, 32'h5566_7788, 4'b0011, 32'h0, 1'b0);       step();
        drv_i(32'h20, 32'h0, 4'h0, 32'h1122_7788, 1'b0);
        drv_d(32'h20, 32'h0, 4'h0, 32'h1122_7788, 1'b0);          step();

        // Out of range: zero data, one-cycle err, no aliased write to word 0.
        drv_d(32'h40, 32'h0, 4'h0, 32'h0, 1'b1);
        drv_i(32'h40, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);          step();
        drv_d(32'h10, 32'h0, 4'h0, 32'hDEAD_AAEF, 1'b0);
        drv_i(32'h0, 32'h0, 4'h0, 32'h0, 1'b0);                   step();

        // Load three words while the inst port reads an unrelated word in parallel.
        drv_d(32'h0, 32'h0101_0101, 4'hF, 32'h0, 1'b0);
        drv_i(32'h3C, 32'h0, 4'h0, 32'h0, 1'b0);                  step();
        drv_d(32'h4, 32'h0202_0202, 4'hF, 32'h0, 1'b0);           step();
        drv_d(32'h8, 32'h0303_0303, 4'hF, 32'h0, 1'b0);           step();
        drv_i(32'h0, 32'h0, 4'h0, 32'h0101_0101, 1'b0);           step();
        drv_i(32'h4, 32'h0, 4'h0, 32'h0202_0202, 1'b0);           step();
        drv_i(32'h8, 32'h0, 4'h0, 32'h0303_0303, 1'b0);           step();
        step();
        check("inst_hold", {err_inst, rdata_inst}, {1'b0, 32'h0303_0303});

        // Reset pulse sampled while the clear counter sits at 7, then accesses during the re-clear.
        aresetn = 1'b1;
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        check("reset2_ready", {32'h0, ready}, 33'h0);
        for (int i = 0; i < 7; i++) step();
        aresetn = 1'b0;
        step();
        check("midclear_reset", {err_inst, err_data, ready, rdata_data}, 35'h0);
        aresetn = 1'b1;
        wait_ready(1'b1);

        drv_i(32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        drv_d(32'h30, 32'h0, 4'h0, 32'h0, 1'b0);                  step();
        drv_i(32'h8, 32'h0, 4'h0, 32'h0, 1'b0);
        drv_d(32'h44, 32'h0, 4'h0, 32'h0, 1'b1);                  step();
        drv_d(32'h3C, 32'h0, 4'h0, 32'h0, 1'b0);                  step();
        step();
        check("drain", 33'(q_inst.size() + q_data.size()), 33'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
